// File: rtl/ex_mc_pkg.sv
// Shared op codes, forward selects, FSM state type and control bundle for the
// multi-cycle execute stage.
package ex_mc_pkg;

  localparam logic [3:0] OP_SUB = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_RF_B = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_DONE = 2'd2
  } mc_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic mov;
    logic valid;
  } ctrl_t;

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH
// cycles, low DATA_WIDTH bits kept. Only built when EX_MC_MUL_EN is defined.
`ifdef EX_MC_MUL_EN
module ex_iter_mul #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  last_s;

  // done_o flags the final step so the owner can change state on the same edge
  assign last_s    = run_q && (cnt_q == CW'(DATA_WIDTH - 1));
  assign done_o    = last_s;
  assign product_o = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (clr_i) begin
      mcand_d  = '0;
      mplier_d = '0;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b0;
    end else if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      run_d    = !last_s;
    end else begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule
`endif

// File: rtl/ex_mc_stage.sv
// Execute stage with forwarding, single-cycle ALU and EX/MEM register.
// EX_MC_MUL_EN adds the iterative MUL op, its FSM and the busy_o stall request.
module ex_mc_stage
  import ex_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int IMM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validE_i,
  input  logic [ADDR_WIDTH-1:0] pcE_i,
  input  logic [IMM_WIDTH-1:0]  immE_i,
  input  logic [REG_WIDTH-1:0]  rsE_i,
  input  logic [REG_WIDTH-1:0]  rdE_i,
  input  logic [DATA_WIDTH-1:0] r1_data_i,
  input  logic [DATA_WIDTH-1:0] r2_data_i,
  input  logic [3:0]            aluopE_i,
  input  logic                  RegWriteE_i,
  input  logic                  RegDstE_i,
  input  logic                  MemReadE_i,
  input  logic                  MemWriteE_i,
  input  logic                  MemToRegE_i,
  input  logic                  BranchE_i,
  input  logic                  MovE_i,
  input  logic [1:0]            fwd1_i,
  input  logic [1:0]            fwd2_i,
  input  logic [DATA_WIDTH-1:0] WBResultM_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] PCM_o,
  output logic [DATA_WIDTH-1:0] WriteDataM_o,
  output logic [DATA_WIDTH-1:0] alu_outM_o,
  output logic [IMM_WIDTH-1:0]  immM_o,
  output logic [REG_WIDTH-1:0]  rsM_o,
  output logic [REG_WIDTH-1:0]  WriteRegM_o,
  output logic                  RegWriteM_o,
  output logic                  MemReadM_o,
  output logic                  MemWriteM_o,
  output logic                  MemToRegM_o,
  output logic                  BranchM_o,
  output logic                  MovM_o,
  output logic                  validM_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] alu;
    logic [IMM_WIDTH-1:0]  imm;
    logic [REG_WIDTH-1:0]  rs;
    logic [REG_WIDTH-1:0]  wr;
    ctrl_t                 ctrl;
  } exmem_t;

  logic [DATA_WIDTH-1:0] op1_s, op2_s, alu_s;
  exmem_t                e_s, ld_s, exmem_q, exmem_d;

  always_comb begin
    case (fwd1_i)
      FWD_MEM: op1_s = WBResultM_i;
      FWD_WB:  op1_s = ResultW_i;
      default: op1_s = r1_data_i;
    endcase
    case (fwd2_i)
      FWD_MEM: op2_s = WBResultM_i;
      FWD_WB:  op2_s = ResultW_i;
      default: op2_s = r2_data_i;
    endcase
  end

  // MUL falls to default here; when enabled it is produced by the multiplier
  always_comb begin
    case (aluopE_i)
      OP_SUB:  alu_s = op1_s - op2_s;
      OP_ADD:  alu_s = op1_s + op2_s;
      OP_SLT:  alu_s = {{(DATA_WIDTH-1){1'b0}}, (op1_s < op2_s)};
      OP_AND:  alu_s = op1_s & op2_s;
      OP_OR:   alu_s = op1_s | op2_s;
      OP_XOR:  alu_s = op1_s ^ op2_s;
      OP_SHL:  alu_s = op1_s << op2_s[SHW-1:0];
      OP_SHR:  alu_s = op1_s >> op2_s[SHW-1:0];
      default: alu_s = '0;
    endcase
  end

  always_comb begin
    e_s.pc              = pcE_i;
    e_s.wd              = op1_s;
    e_s.alu             = alu_s;
    e_s.imm             = immE_i;
    e_s.rs              = rsE_i;
    e_s.wr              = RegDstE_i ? rsE_i : rdE_i;
    e_s.ctrl.reg_write  = RegWriteE_i;
    e_s.ctrl.mem_read   = MemReadE_i;
    e_s.ctrl.mem_write  = MemWriteE_i;
    e_s.ctrl.mem_to_reg = MemToRegE_i;
    e_s.ctrl.branch     = BranchE_i;
    e_s.ctrl.mov        = MovE_i;
    e_s.ctrl.valid      = validE_i;
  end

`ifdef EX_MC_MUL_EN
  mc_state_e             state_q, state_d;
  exmem_t                lat_q, lat_d;
  logic                  start_s, mul_done_s;
  logic [DATA_WIDTH-1:0] product_s;

  // A flushed instruction never starts a multiply
  assign start_s = (state_q == ST_IDLE) && validE_i && (aluopE_i == OP_MUL) && !flush_i;

  ex_iter_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush_i),
    .start_i   (start_s),
    .a_i       (op1_s),
    .b_i       (op2_s),
    .done_o    (mul_done_s),
    .product_o (product_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    if (start_s) begin
      lat_d = e_s;
    end else if (flush_i) begin
      lat_d = '0;
    end else begin
      lat_d = lat_q;
    end
    case (state_q)
      ST_IDLE:     state_d = start_s ? ST_MUL_BUSY : ST_IDLE;
      ST_MUL_BUSY: state_d = flush_i ? ST_IDLE : (mul_done_s ? ST_MUL_DONE : ST_MUL_BUSY);
      ST_MUL_DONE: state_d = flush_i ? ST_IDLE : (stall_i ? ST_MUL_DONE : ST_IDLE);
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    ld_s   = '0;
    case (state_q)
      ST_IDLE: begin
        busy_o = start_s;
        if (!start_s && validE_i) begin
          ld_s = e_s;
        end else begin
          ld_s = '0;
        end
      end
      ST_MUL_BUSY: begin
        busy_o = 1'b1;
        ld_s   = '0;
      end
      ST_MUL_DONE: begin
        busy_o = stall_i;
        ld_s   = lat_q;
        ld_s.alu = product_s;
      end
      default: begin
        busy_o = 1'b0;
        ld_s   = '0;
      end
    endcase
  end
`else
  assign busy_o = 1'b0;

  always_comb begin
    if (validE_i) begin
      ld_s = e_s;
    end else begin
      ld_s = '0;
    end
  end
`endif

  always_comb begin
    if (flush_i) begin
      exmem_d = '0;
    end else if (stall_i) begin
      exmem_d = exmem_q;
    end else begin
      exmem_d = ld_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign PCM_o        = exmem_q.pc;
  assign WriteDataM_o = exmem_q.wd;
  assign alu_outM_o   = exmem_q.alu;
  assign immM_o       = exmem_q.imm;
  assign rsM_o        = exmem_q.rs;
  assign WriteRegM_o  = exmem_q.wr;
  assign RegWriteM_o  = exmem_q.ctrl.reg_write;
  assign MemReadM_o   = exmem_q.ctrl.mem_read;
  assign MemWriteM_o  = exmem_q.ctrl.mem_write;
  assign MemToRegM_o  = exmem_q.ctrl.mem_to_reg;
  assign BranchM_o    = exmem_q.ctrl.branch;
  assign MovM_o       = exmem_q.ctrl.mov;
  assign validM_o     = exmem_q.ctrl.valid;

endmodule

// File: tb/tb_ex_mc_stage.sv
// Directed, table-driven bench for ex_mc_stage at default parameters.
// Multiply sequences are exercised when EX_MC_MUL_EN is defined, op 8 otherwise.
module tb_ex_mc_stage;

  logic        clk = 1'b0;
  logic        rst, validE_i, RegWriteE_i, RegDstE_i, MemReadE_i, MemWriteE_i;
  logic        MemToRegE_i, BranchE_i, MovE_i, flush_i, stall_i;
  logic [7:0]  pcE_i, immE_i;
  logic [3:0]  rsE_i, rdE_i, aluopE_i;
  logic [15:0] r1_data_i, r2_data_i, WBResultM_i, ResultW_i;
  logic [1:0]  fwd1_i, fwd2_i;
  logic        busy_o, RegWriteM_o, MemReadM_o, MemWriteM_o, MemToRegM_o;
  logic        BranchM_o, MovM_o, validM_o;
  logic [7:0]  PCM_o, immM_o;
  logic [15:0] WriteDataM_o, alu_outM_o;
  logic [3:0]  rsM_o, WriteRegM_o;
  logic [5:0]  ctl_m;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ctl_m = {RegWriteM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, BranchM_o, MovM_o};

  ex_mc_stage dut (
    .clk(clk), .rst(rst), .validE_i(validE_i), .pcE_i(pcE_i), .immE_i(immE_i),
    .rsE_i(rsE_i), .rdE_i(rdE_i), .r1_data_i(r1_data_i), .r2_data_i(r2_data_i),
    .aluopE_i(aluopE_i), .RegWriteE_i(RegWriteE_i), .RegDstE_i(RegDstE_i),
    .MemReadE_i(MemReadE_i), .MemWriteE_i(MemWriteE_i), .MemToRegE_i(MemToRegE_i),
    .BranchE_i(BranchE_i), .MovE_i(MovE_i), .fwd1_i(fwd1_i), .fwd2_i(fwd2_i),
    .WBResultM_i(WBResultM_i), .ResultW_i(ResultW_i), .flush_i(flush_i),
    .stall_i(stall_i), .busy_o(busy_o), .PCM_o(PCM_o), .WriteDataM_o(WriteDataM_o),
    .alu_outM_o(alu_outM_o), .immM_o(immM_o), .rsM_o(rsM_o),
    .WriteRegM_o(WriteRegM_o), .RegWriteM_o(RegWriteM_o), .MemReadM_o(MemReadM_o),
    .MemWriteM_o(MemWriteM_o), .MemToRegM_o(MemToRegM_o), .BranchM_o(BranchM_o),
    .MovM_o(MovM_o), .validM_o(validM_o)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [1:0]  f1, f2;
    logic [15:0] r1, r2, wbm, resw;
    logic        regdst;
    logic [5:0]  ctl;
    logic [15:0] exp_alu, exp_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [1:0] f1, f2,
                              input logic [15:0] r1, r2, wbm, resw, input logic regdst,
                              input logic [5:0] ctl, input logic [15:0] ea, ew);
    vec_t t;
    t.valid = v; t.op = op; t.f1 = f1; t.f2 = f2; t.r1 = r1; t.r2 = r2;
    t.wbm = wbm; t.resw = resw; t.regdst = regdst; t.ctl = ctl;
    t.exp_alu = ea; t.exp_wd = ew;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] f1, f2,
                       input logic [15:0] r1, r2, wbm, resw, input logic regdst,
                       input logic [5:0] ctl, input logic [7:0] pc, imm,
                       input logic [3:0] rs, rd);
    validE_i = v; aluopE_i = op; fwd1_i = f1; fwd2_i = f2;
    r1_data_i = r1; r2_data_i = r2; WBResultM_i = wbm; ResultW_i = resw;
    RegDstE_i = regdst;
    {RegWriteE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, BranchE_i, MovE_i} = ctl;
    pcE_i = pc; immE_i = imm; rsE_i = rs; rdE_i = rd;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 4'd1, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 6'b0, 8'h0, 8'h0, 4'd0, 4'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 32'(validM_o), 32'h0);
    chk({nm, "_ctl"}, 32'(ctl_m), 32'h0);
    chk({nm, "_alu"}, 32'(alu_outM_o), 32'h0);
    chk({nm, "_wd"}, 32'(WriteDataM_o), 32'h0);
    chk({nm, "_pc"}, 32'({PCM_o, immM_o, rsM_o, WriteRegM_o}), 32'h0);
  endtask

  initial begin
    int seen_valid;
    int seen_busy;
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b1, 4'd1, 2'd0, 2'd0, 16'h1111, 16'h2222, 16'h0, 16'h0, 1'b1, 6'b111111,
          8'h77, 8'h66, 4'd5, 4'd6);
    step(); step();
    chk_zero("reset");
    chk("reset_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;

    vecs.push_back(mk(1, 4'd1, 0, 0, 16'hFFFF, 16'h0002, 16'h1234, 16'h5678, 0, 6'b100000, 16'h0001, 16'hFFFF));
    vecs.push_back(mk(1, 4'd2, 1, 0, 16'h0009, 16'h0005, 16'h0003, 16'h0000, 1, 6'b100000, 16'h0001, 16'h0003));
    vecs.push_back(mk(1, 4'd7, 0, 0, 16'h8000, 16'h001F, 16'h0000, 16'h0000, 0, 6'b100001, 16'h0001, 16'h8000));
    vecs.push_back(mk(1, 4'd0, 0, 2, 16'h0005, 16'h1111, 16'h0000, 16'h0007, 1, 6'b100000, 16'hFFFE, 16'h0005));
    vecs.push_back(mk(1, 4'd3, 3, 3, 16'hF0F0, 16'h3C3C, 16'hAAAA, 16'h5555, 0, 6'b100000, 16'h3030, 16'hF0F0));
    vecs.push_back(mk(1, 4'd4, 2, 1, 16'h0000, 16'h0000, 16'h000F, 16'hF000, 0, 6'b010100, 16'hF00F, 16'hF000));
    vecs.push_back(mk(1, 4'd5, 0, 0, 16'hFFFF, 16'h0F0F, 16'h0000, 16'h0000, 1, 6'b001000, 16'hF0F0, 16'hFFFF));
    vecs.push_back(mk(1, 4'd6, 0, 0, 16'h0001, 16'h0014, 16'h0000, 16'h0000, 0, 6'b000010, 16'h0010, 16'h0001));
    vecs.push_back(mk(1, 4'd9, 0, 0, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 0, 6'b000001, 16'h0000, 16'h1234));
    vecs.push_back(mk(1, 4'd15, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1, 6'b100000, 16'h0000, 16'hFFFF));
    vecs.push_back(mk(1, 4'd2, 0, 0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 0, 6'b100000, 16'h0000, 16'h0005));
    vecs.push_back(mk(1, 4'd2, 0, 0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 0, 6'b100000, 16'h0001, 16'h0001));
    vecs.push_back(mk(1, 4'd1, 0, 0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 0, 6'b100000, 16'h0000, 16'h8000));
    vecs.push_back(mk(0, 4'd1, 0, 0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 0, 6'b111111, 16'h0000, 16'h0000));
`ifndef EX_MC_MUL_EN
    vecs.push_back(mk(1, 4'd8, 0, 0, 16'h0012, 16'h0034, 16'h0000, 16'h0000, 0, 6'b100000, 16'h0000, 16'h0012));
`endif

    foreach (vecs[i]) begin
      logic [7:0] pc, imm;
      logic [3:0] rs, rd;
      pc = 8'(8'h10 + i); imm = 8'(8'hA0 + i); rs = 4'(i); rd = 4'(15 - i);
      drive(vecs[i].valid, vecs[i].op, vecs[i].f1, vecs[i].f2, vecs[i].r1, vecs[i].r2,
            vecs[i].wbm, vecs[i].resw, vecs[i].regdst, vecs[i].ctl, pc, imm, rs, rd);
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'h0);
      step();
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_alu", i), 32'(alu_outM_o), 32'(vecs[i].exp_alu));
        chk($sformatf("v%0d_wd", i), 32'(WriteDataM_o), 32'(vecs[i].exp_wd));
        chk($sformatf("v%0d_wreg", i), 32'(WriteRegM_o), 32'(vecs[i].regdst ? rs : rd));
        chk($sformatf("v%0d_fields", i), 32'({PCM_o, immM_o, rsM_o}), 32'({pc, imm, rs}));
        chk($sformatf("v%0d_ctl", i), 32'(ctl_m), 32'(vecs[i].ctl));
        chk($sformatf("v%0d_valid", i), 32'(validM_o), 32'h1);
      end else begin
        chk($sformatf("v%0d_bubble_valid", i), 32'(validM_o), 32'h0);
        chk($sformatf("v%0d_bubble_ctl", i), 32'(ctl_m), 32'h0);
      end
    end

    // stall holds EX/MEM, flush clears it
    drive(1'b1, 4'd1, 2'd0, 2'd0, 16'h0001, 16'h0001, 16'h0, 16'h0, 1'b0, 6'b100000, 8'h21, 8'h22, 4'd1, 4'd2);
    step();
    chk("pre_stall_alu", 32'(alu_outM_o), 32'h2);
    stall_i = 1'b1;
    drive(1'b1, 4'd5, 2'd0, 2'd0, 16'h00FF, 16'h0F00, 16'h0, 16'h0, 1'b1, 6'b010000, 8'h31, 8'h32, 4'd3, 4'd4);
    step();
    chk("stall_alu", 32'(alu_outM_o), 32'h2);
    chk("stall_pc", 32'(PCM_o), 32'h21);
    stall_i = 1'b0; flush_i = 1'b1; #1;
    step();
    chk_zero("flush");
    flush_i = 1'b0;

`ifdef EX_MC_MUL_EN
    // full multiply: busy through 16 step cycles, product DATA_WIDTH+1 edges after accept
    drive(1'b1, 4'd8, 2'd0, 2'd0, 16'h0012, 16'h0034, 16'h0, 16'h0, 1'b0, 6'b100001, 8'h40, 8'h55, 4'd3, 4'd9);
    chk("mul_accept_busy", 32'(busy_o), 32'h1);
    step();
    chk("mul_accept_bubble", 32'(validM_o), 32'h0);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("mul_busy_c%0d", c), 32'(busy_o), 32'h1);
      step();
      chk($sformatf("mul_bubble_c%0d", c), 32'({validM_o, ctl_m}), 32'h0);
    end
    chk("mul_done_busy", 32'(busy_o), 32'h0);
    step();
    chk("mul_product", 32'(alu_outM_o), 32'h03A8);
    chk("mul_valid", 32'(validM_o), 32'h1);
    chk("mul_fields", 32'({PCM_o, immM_o, rsM_o, WriteRegM_o}), 32'h40553_9);
    chk("mul_wd_ctl", 32'({WriteDataM_o, 2'b00, ctl_m}), 32'h0012_0021);
    bubble();
    chk("mul_after_busy", 32'(busy_o), 32'h0);
    step();
    chk("mul_after_bubble", 32'(validM_o), 32'h0);

    // flush at busy cycle 5 aborts the multiply
    drive(1'b1, 4'd8, 2'd0, 2'd0, 16'h0003, 16'h0005, 16'h0, 16'h0, 1'b0, 6'b100000, 8'h50, 8'h00, 4'd1, 4'd2);
    step();
    for (int c = 1; c <= 4; c++) step();
    flush_i = 1'b1; #1;
    step();
    flush_i = 1'b0;
    bubble();
    chk_zero("mul_flush");
    chk("mul_flush_busy", 32'(busy_o), 32'h0);
    seen_valid = 0; seen_busy = 0;
    for (int c = 0; c < 20; c++) begin
      seen_busy += int'(busy_o);
      step();
      seen_valid += int'(validM_o);
    end
    chk("mul_flush_no_product", 32'(seen_valid), 32'h0);
    chk("mul_flush_no_busy", 32'(seen_busy), 32'h0);

    // stall held in MUL_DONE for 3 cycles
    drive(1'b1, 4'd8, 2'd0, 2'd0, 16'h0007, 16'h0009, 16'h0, 16'h0, 1'b1, 6'b100000, 8'h60, 8'h61, 4'd7, 4'd8);
    step();
    for (int c = 1; c <= 16; c++) step();
    stall_i = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mul_stall_busy%0d", k), 32'(busy_o), 32'h1);
      step();
      chk($sformatf("mul_stall_hold%0d", k), 32'({validM_o, alu_outM_o}), 32'h0);
    end
    stall_i = 1'b0; #1;
    chk("mul_unstall_busy", 32'(busy_o), 32'h0);
    step();
    chk("mul_stall_product", 32'({validM_o, alu_outM_o}), 32'h1_003F);
    chk("mul_stall_wreg", 32'(WriteRegM_o), 32'h7);
    bubble();
    step();

    // reset mid-multiply
    drive(1'b1, 4'd8, 2'd0, 2'd0, 16'h00FF, 16'h0101, 16'h0, 16'h0, 1'b0, 6'b100000, 8'h70, 8'h71, 4'd1, 4'd2);
    step();
    for (int c = 1; c <= 6; c++) step();
    rst = 1'b1;
    bubble();
    step();
    rst = 1'b0; #1;
    chk_zero("mul_rst");
    chk("mul_rst_busy", 32'(busy_o), 32'h0);
    drive(1'b1, 4'd1, 2'd0, 2'd0, 16'h0010, 16'h0020, 16'h0, 16'h0, 1'b0, 6'b100000, 8'h80, 8'h81, 4'd1, 4'd2);
    chk("post_rst_busy", 32'(busy_o), 32'h0);
    step();
    chk("post_rst_add", 32'({validM_o, alu_outM_o}), 32'h1_0030);
    bubble();
    seen_valid = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      seen_valid += int'(validM_o);
    end
    chk("mul_rst_no_product", 32'(seen_valid), 32'h0);
`else
    // op 8 without the multiplier: single-cycle zero, never busy
    drive(1'b1, 4'd8, 2'd0, 2'd0, 16'h0012, 16'h0034, 16'h0, 16'h0, 1'b0, 6'b100000, 8'h40, 8'h55, 4'd3, 4'd9);
    seen_valid = 0; seen_busy = 0;
    for (int c = 0; c < 20; c++) begin
      seen_busy += int'(busy_o);
      step();
      seen_valid += int'(validM_o === 1'b1 && alu_outM_o === 16'h0);
    end
    chk("op8_never_busy", 32'(seen_busy), 32'h0);
    chk("op8_zero_each_cycle", 32'(seen_valid), 32'd20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mc_stage.md
EX_MC_STAGE -- requirements
Module: ex_mc_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, operand/result width (even, 8..32).
REQ-002 SHALL have parameter ADDR_WIDTH, 8, PC width.
REQ-003 SHALL have parameter REG_WIDTH, 4, register index width.
REQ-004 SHALL have parameter IMM_WIDTH, 8, immediate width.
REQ-005 SHALL have ports clk in 1 clock; rst in 1 reset; one clock, reset synchronous active-high.
REQ-006 SHALL have ports validE_i in 1 instr valid; pcE_i in ADDR_WIDTH; immE_i in IMM_WIDTH; rsE_i, rdE_i in REG_WIDTH; r1_data_i, r2_data_i in DATA_WIDTH RF reads.
REQ-007 SHALL have ports aluopE_i in 4 op code; RegWriteE_i, RegDstE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, BranchE_i, MovE_i in 1 each.
REQ-008 SHALL have ports fwd1_i, fwd2_i in 2 forward select; WBResultM_i, ResultW_i in DATA_WIDTH forwarded data; flush_i, stall_i in 1 EX/MEM control.
REQ-009 SHALL have ports busy_o out 1 upstream stall request; PCM_o, WriteDataM_o, alu_outM_o, immM_o, rsM_o, WriteRegM_o registered outs; RegWriteM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, BranchM_o, MovM_o, validM_o out 1.

Function
REQ-010 Forward mux per operand SHALL select 0 RF, 1 WBResultM_i, 2 ResultW_i, 3 RF.
REQ-011 Ops SHALL be 0 SUB, 1 ADD, 2 SLT unsigned (zero-extended 1/0), 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR logical (shift amount = in2 low log2(DATA_WIDTH) bits), 8 MUL (low DATA_WIDTH bits), others -> result 0.
REQ-012 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH.
REQ-013 Single-cycle ops SHALL reach EX/MEM one clock after acceptance.
REQ-014 FSM SHALL have states IDLE, MUL_BUSY, MUL_DONE.
REQ-015 IDLE: validE_i with op MUL SHALL latch operands, zero counter, enter MUL_BUSY; busy_o=1 same cycle combinationally.
REQ-016 MUL_BUSY SHALL perform one shift-add step per cycle for DATA_WIDTH cycles, busy_o=1, EX/MEM loading a bubble (validM_o and all control outs 0) unless stall_i.
REQ-017 After last step SHALL enter MUL_DONE: busy_o=0, EX/MEM loads product with latched pc/reg/control fields, return IDLE; total latency DATA_WIDTH+1 cycles.
REQ-018 MUL_DONE with stall_i SHALL remain in MUL_DONE, busy_o=1, EX/MEM held.
REQ-019 EX/MEM priority SHALL be rst > flush_i (all outs 0) > stall_i (hold) > load.
REQ-020 flush_i in MUL_BUSY or MUL_DONE SHALL abort to IDLE, discard product, busy_o=0 next cycle.
REQ-021 WriteDataM_o SHALL be forwarded operand 1; WriteRegM_o SHALL be rsE_i if RegDstE_i else rdE_i.
REQ-022 validE_i=0 SHALL load a bubble.

Reset
REQ-023 rst SHALL clear all EX/MEM outputs, counter and latches to 0 and FSM to IDLE at next posedge clk, including mid-multiply.

Configuration
REQ-024 Macro EX_MC_MUL_EN defined SHALL include MUL op, FSM and multiplier.
REQ-025 Macro EX_MC_MUL_EN undefined SHALL treat op 8 as unsupported (result 0, single-cycle), busy_o tied 0, no multiplier logic.

Structure
REQ-026 Package ex_mc_pkg SHALL hold op-code constants, FSM state typedef and forward-select constants.
REQ-027 Multiplier SHALL be sub-module ex_iter_mul (start, operands, done, product).

Verification
REQ-028 ADD 0xFFFF+0x0002, fwd 0/0 -> alu_outM_o=0x0001 one clock later.
REQ-029 SLT fwd1=1 WBResultM_i=0x0003, r2=0x0005 -> alu_outM_o=0x0001; SHR 0x8000 by 15 -> 0x0001.
REQ-030 MUL 0x0012*0x0034 -> busy_o high 16 cycles, bubbles in EX/MEM, product 0x03A8 at cycle 17.
REQ-031 MUL with flush_i at busy cycle 5 -> EX/MEM zero, busy_o 0 next cycle, no product emerges.
REQ-032 MUL_DONE with stall_i 3 cycles -> EX/MEM held, product loaded when stall_i drops; rst mid-multiply -> all outs 0, IDLE.
REQ-033 Build without EX_MC_MUL_EN, op 8 -> alu_outM_o=0, busy_o never asserted.
